// File: rtl/lsu_port_arbiter_if.sv
// lsu_port_arbiter_if
// Bundles every request, grant, load-return and LSU-side signal around the
// LSU port arbiter. Signal names are written from the arbiter's point of view:
// i_* are inputs to the arbiter and o_* are its outputs.
//   slave  : arbiter side (takes requests and i_ld_data, drives grants and the LSU request)
//   master : requester/LSU side (drives requests and i_ld_data, observes the arbiter outputs)
interface lsu_port_arbiter_if;
  // CPU (port 0)
  logic        i_cpu_req;
  logic [31:0] i_cpu_addr;
  logic [31:0] i_cpu_st_data;
  logic        i_cpu_wren;
  logic [2:0]  i_cpu_bmask;
  logic [2:0]  i_cpu_sl_sel;
  logic        o_cpu_gnt;
  logic        o_cpu_stall;
  logic [31:0] o_cpu_ld_data;
  logic        o_cpu_rvalid;
  // DMA / debug loader (port 1)
  logic        i_dma_req;
  logic [31:0] i_dma_addr;
  logic [31:0] i_dma_st_data;
  logic        i_dma_wren;
  logic [2:0]  i_dma_bmask;
  logic [2:0]  i_dma_sl_sel;
  logic        i_dma_lock;
  logic        o_dma_gnt;
  logic [31:0] o_dma_ld_data;
  logic        o_dma_rvalid;
  // LSU side
  logic [31:0] o_lsu_addr;
  logic [31:0] o_st_data;
  logic        o_lsu_wren;
  logic [2:0]  o_bmask;
  logic [2:0]  o_sl_sel;
  logic [31:0] i_ld_data;

  modport slave (
    input  i_cpu_req, i_cpu_addr, i_cpu_st_data, i_cpu_wren, i_cpu_bmask, i_cpu_sl_sel,
    input  i_dma_req, i_dma_addr, i_dma_st_data, i_dma_wren, i_dma_bmask, i_dma_sl_sel,
    input  i_dma_lock, i_ld_data,
    output o_cpu_gnt, o_cpu_stall, o_cpu_ld_data, o_cpu_rvalid,
    output o_dma_gnt, o_dma_ld_data, o_dma_rvalid,
    output o_lsu_addr, o_st_data, o_lsu_wren, o_bmask, o_sl_sel
  );

  modport master (
    output i_cpu_req, i_cpu_addr, i_cpu_st_data, i_cpu_wren, i_cpu_bmask, i_cpu_sl_sel,
    output i_dma_req, i_dma_addr, i_dma_st_data, i_dma_wren, i_dma_bmask, i_dma_sl_sel,
    output i_dma_lock, i_ld_data,
    input  o_cpu_gnt, o_cpu_stall, o_cpu_ld_data, o_cpu_rvalid,
    input  o_dma_gnt, o_dma_ld_data, o_dma_rvalid,
    input  o_lsu_addr, o_st_data, o_lsu_wren, o_bmask, o_sl_sel
  );
endinterface

// File: rtl/lsu_port_arbiter.sv
// lsu_port_arbiter
// Shares the single LSU port between the CPU MEM stage (port 0) and a
// DMA/debug loader (port 1). The CPU has fixed priority, a DMA that has been
// refused MAX_WAIT cycles in a row wins once, and a locked DMA burst keeps
// the port for up to LOCK_MAX beats before yielding one beat to a waiting CPU.
// Load data is returned registered, one cycle after the granted read.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : lsu_port_arbiter_if.slave (requests, grants, load return, LSU request)
module lsu_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  lsu_port_arbiter_if.slave   bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int LOCK_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_OWN  = 2'd1,
    DMA_OWN  = 2'd2,
    DMA_LOCK = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [31:0]       cpu_ld_q, cpu_ld_d;
  logic [31:0]       dma_ld_q, dma_ld_d;
  logic              cpu_rv_q, cpu_rv_d;
  logic              dma_rv_q, dma_rv_d;

  logic cpu_gnt_s, dma_gnt_s;
  logic lock_full_s, lock_hold_s, starve_s;

  // Grant selection in priority order; nothing is granted while reset is held
  always_comb begin
    cpu_gnt_s   = 1'b0;
    dma_gnt_s   = 1'b0;
    lock_full_s = (lock_cnt_q == LOCK_W'(LOCK_MAX));
    lock_hold_s = (state_q == DMA_LOCK) && bus.i_dma_req &&
                  !(lock_full_s && bus.i_cpu_req);
    starve_s    = bus.i_dma_req && (wait_cnt_q == WAIT_W'(MAX_WAIT));
    if (!i_reset) begin
      cpu_gnt_s = 1'b0;
      dma_gnt_s = 1'b0;
    end else if (lock_hold_s) begin
      dma_gnt_s = 1'b1;
    end else if (starve_s) begin
      dma_gnt_s = 1'b1;
    end else if (bus.i_cpu_req) begin
      cpu_gnt_s = 1'b1;
    end else if (bus.i_dma_req) begin
      dma_gnt_s = 1'b1;
    end else begin
      cpu_gnt_s = 1'b0;
      dma_gnt_s = 1'b0;
    end
  end

  // LSU request mux: granted requester passes through, otherwise all zero
  always_comb begin
    bus.o_lsu_addr = 32'd0;
    bus.o_st_data  = 32'd0;
    bus.o_lsu_wren = 1'b0;
    bus.o_bmask    = 3'd0;
    bus.o_sl_sel   = 3'd0;
    if (cpu_gnt_s) begin
      bus.o_lsu_addr = bus.i_cpu_addr;
      bus.o_st_data  = bus.i_cpu_st_data;
      bus.o_lsu_wren = bus.i_cpu_wren;
      bus.o_bmask    = bus.i_cpu_bmask;
      bus.o_sl_sel   = bus.i_cpu_sl_sel;
    end else if (dma_gnt_s) begin
      bus.o_lsu_addr = bus.i_dma_addr;
      bus.o_st_data  = bus.i_dma_st_data;
      bus.o_lsu_wren = bus.i_dma_wren;
      bus.o_bmask    = bus.i_dma_bmask;
      bus.o_sl_sel   = bus.i_dma_sl_sel;
    end else begin
      bus.o_lsu_wren = 1'b0;
    end
  end

  // Next owner/lock state, starvation and lock counters, load-return capture
  always_comb begin
    state_d    = IDLE;
    wait_cnt_d = wait_cnt_q;
    lock_cnt_d = '0;
    cpu_rv_d   = cpu_gnt_s & ~bus.i_cpu_wren;
    dma_rv_d   = dma_gnt_s & ~bus.i_dma_wren;
    cpu_ld_d   = cpu_ld_q;
    dma_ld_d   = dma_ld_q;

    if (dma_gnt_s) begin
      state_d = bus.i_dma_lock ? DMA_LOCK : DMA_OWN;
    end else if (cpu_gnt_s) begin
      state_d = CPU_OWN;
    end else begin
      state_d = IDLE;
    end

    // Refused-request counter; any DMA grant or dropped request restarts it
    if (!bus.i_dma_req || dma_gnt_s) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q;
    end else begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    // Every DMA beat that lands in DMA_LOCK counts, including the one that
    // enters it, so a burst gets exactly LOCK_MAX beats before a CPU break.
    // Leaving the lock (or a forced break, which is a CPU grant) clears it.
    if (dma_gnt_s && bus.i_dma_lock) begin
      if (lock_full_s) begin
        lock_cnt_d = lock_cnt_q;
      end else begin
        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      end
    end else begin
      lock_cnt_d = '0;
    end

    if (cpu_rv_d) begin
      cpu_ld_d = bus.i_ld_data;
    end else begin
      cpu_ld_d = cpu_ld_q;
    end
    if (dma_rv_d) begin
      dma_ld_d = bus.i_ld_data;
    end else begin
      dma_ld_d = dma_ld_q;
    end
  end

  // State, counters and registered load return
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      lock_cnt_q <= '0;
      cpu_ld_q   <= 32'd0;
      dma_ld_q   <= 32'd0;
      cpu_rv_q   <= 1'b0;
      dma_rv_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      cpu_ld_q   <= cpu_ld_d;
      dma_ld_q   <= dma_ld_d;
      cpu_rv_q   <= cpu_rv_d;
      dma_rv_q   <= dma_rv_d;
    end
  end

  assign bus.o_cpu_gnt     = cpu_gnt_s;
  assign bus.o_dma_gnt     = dma_gnt_s;
  assign bus.o_cpu_stall   = bus.i_cpu_req & ~cpu_gnt_s;
  assign bus.o_cpu_ld_data = cpu_ld_q;
  assign bus.o_dma_ld_data = dma_ld_q;
  assign bus.o_cpu_rvalid  = cpu_rv_q;
  assign bus.o_dma_rvalid  = dma_rv_q;

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// tb_lsu_port_arbiter
// Directed bench for lsu_port_arbiter (MAX_WAIT=4, LOCK_MAX=8). Inputs change
// 2 time units after a rising edge and outputs are sampled 1 unit later.
module tb_lsu_port_arbiter;
  logic i_clk = 1'b0;
  logic i_reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [19:0] lock_pat;

  lsu_port_arbiter_if bus();

  lsu_port_arbiter #(.MAX_WAIT(4), .LOCK_MAX(8)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  initial begin
    // Reset with both requests held
    i_reset           = 1'b0;
    bus.i_cpu_req     = 1'b1;
    bus.i_cpu_addr    = 32'h0000_0040;
    bus.i_cpu_st_data = 32'h0000_0000;
    bus.i_cpu_wren    = 1'b1;
    bus.i_cpu_bmask   = 3'd0;
    bus.i_cpu_sl_sel  = 3'd0;
    bus.i_dma_req     = 1'b1;
    bus.i_dma_addr    = 32'h0000_0080;
    bus.i_dma_st_data = 32'h0000_0000;
    bus.i_dma_wren    = 1'b1;
    bus.i_dma_bmask   = 3'd0;
    bus.i_dma_sl_sel  = 3'd0;
    bus.i_dma_lock    = 1'b0;
    bus.i_ld_data     = 32'h0000_0000;
    #1;
    chk1 ("rst_cpu_gnt",    bus.o_cpu_gnt, 1'b0);
    chk1 ("rst_dma_gnt",    bus.o_dma_gnt, 1'b0);
    chk32("rst_lsu_addr",   bus.o_lsu_addr, 32'h0);
    chk1 ("rst_lsu_wren",   bus.o_lsu_wren, 1'b0);
    chk1 ("rst_cpu_rvalid", bus.o_cpu_rvalid, 1'b0);
    chk1 ("rst_dma_rvalid", bus.o_dma_rvalid, 1'b0);
    chk32("rst_cpu_ld",     bus.o_cpu_ld_data, 32'h0);
    chk32("rst_dma_ld",     bus.o_dma_ld_data, 32'h0);
    tick();
    tick();

    // First cycle after release: CPU wins, read of 0x11111111
    i_reset        = 1'b1;
    bus.i_cpu_wren = 1'b0;
    bus.i_ld_data  = 32'h1111_1111;
    #1;
    chk1 ("rel_cpu_gnt",   bus.o_cpu_gnt, 1'b1);
    chk1 ("rel_cpu_stall", bus.o_cpu_stall, 1'b0);
    chk1 ("rel_dma_gnt",   bus.o_dma_gnt, 1'b0);
    chk32("rel_lsu_addr",  bus.o_lsu_addr, 32'h0000_0040);
    tick();
    bus.i_cpu_req = 1'b0;
    bus.i_dma_req = 1'b0;
    bus.i_ld_data = 32'h0;
    #1;
    chk1 ("rel_cpu_rvalid", bus.o_cpu_rvalid, 1'b1);
    chk32("rel_cpu_ld",     bus.o_cpu_ld_data, 32'h1111_1111);
    chk1 ("idle_cpu_gnt",   bus.o_cpu_gnt, 1'b0);
    chk32("idle_lsu_addr",  bus.o_lsu_addr, 32'h0);
    tick();

    // CPU read of 0x10 returning 0xDEADBEEF
    bus.i_cpu_req  = 1'b1;
    bus.i_cpu_addr = 32'h0000_0010;
    bus.i_cpu_wren = 1'b0;
    bus.i_ld_data  = 32'hDEAD_BEEF;
    #1;
    chk1 ("rd_cpu_rvalid0", bus.o_cpu_rvalid, 1'b0);
    chk1 ("rd_cpu_gnt",     bus.o_cpu_gnt, 1'b1);
    chk32("rd_lsu_addr",    bus.o_lsu_addr, 32'h0000_0010);
    chk1 ("rd_lsu_wren",    bus.o_lsu_wren, 1'b0);
    tick();
    bus.i_cpu_req = 1'b0;
    bus.i_ld_data = 32'h0;
    #1;
    chk32("rd_cpu_ld",      bus.o_cpu_ld_data, 32'hDEAD_BEEF);
    chk1 ("rd_cpu_rvalid1", bus.o_cpu_rvalid, 1'b1);
    chk1 ("rd_dma_rvalid",  bus.o_dma_rvalid, 1'b0);
    tick();
    #1;
    chk1 ("rd_cpu_rvalid2", bus.o_cpu_rvalid, 1'b0);
    chk32("rd_cpu_ld_hold", bus.o_cpu_ld_data, 32'hDEAD_BEEF);
    tick();

    // Continuous contention without lock: 4 CPU beats, then 1 DMA beat
    bus.i_cpu_req  = 1'b1;
    bus.i_cpu_addr = 32'h0000_0100;
    bus.i_cpu_wren = 1'b1;
    bus.i_dma_req  = 1'b1;
    bus.i_dma_addr = 32'h2000_0200;
    bus.i_dma_wren = 1'b1;
    bus.i_dma_lock = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk1 ("alt_dma_gnt",   bus.o_dma_gnt,   (k % 5) == 4);
      chk1 ("alt_cpu_gnt",   bus.o_cpu_gnt,   (k % 5) != 4);
      chk1 ("alt_cpu_stall", bus.o_cpu_stall, (k % 5) == 4);
      chk32("alt_lsu_addr",  bus.o_lsu_addr,
            ((k % 5) == 4) ? 32'h2000_0200 : 32'h0000_0100);
      tick();
    end

    // Locked 12-beat DMA burst with CPU requesting throughout:
    // CCCC DDDDDDDD C CCC DDDD (index 0 first, 1 = DMA)
    bus.i_dma_lock = 1'b1;
    lock_pat = 20'b1111_0000_1111_1111_0000;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk1("lock_dma_gnt", bus.o_dma_gnt, lock_pat[i]);
      chk1("lock_cpu_gnt", bus.o_cpu_gnt, ~lock_pat[i]);
      tick();
    end
    bus.i_cpu_req  = 1'b0;
    bus.i_dma_req  = 1'b0;
    bus.i_dma_lock = 1'b0;
    #1;
    chk1("none_cpu_gnt",  bus.o_cpu_gnt, 1'b0);
    chk1("none_dma_gnt",  bus.o_dma_gnt, 1'b0);
    chk1("none_lsu_wren", bus.o_lsu_wren, 1'b0);
    tick();

    // DMA store, CPU idle
    bus.i_dma_req     = 1'b1;
    bus.i_dma_addr    = 32'h1000_0000;
    bus.i_dma_st_data = 32'h0001_FFFF;
    bus.i_dma_wren    = 1'b1;
    bus.i_dma_bmask   = 3'd3;
    #1;
    chk1 ("st_dma_gnt",  bus.o_dma_gnt, 1'b1);
    chk1 ("st_lsu_wren", bus.o_lsu_wren, 1'b1);
    chk32("st_st_data",  bus.o_st_data, 32'h0001_FFFF);
    chk32("st_lsu_addr", bus.o_lsu_addr, 32'h1000_0000);
    chk32("st_bmask",    {29'd0, bus.o_bmask}, 32'd3);
    tick();
    bus.i_dma_req = 1'b0;
    #1;
    chk1 ("st_dma_rvalid", bus.o_dma_rvalid, 1'b0);
    chk1 ("st_wren_off",   bus.o_lsu_wren, 1'b0);
    chk32("st_dma_ld",     bus.o_dma_ld_data, 32'h0);
    tick();

    // Back-to-back DMA reads
    bus.i_dma_req  = 1'b1;
    bus.i_dma_addr = 32'h0000_0300;
    bus.i_dma_wren = 1'b0;
    bus.i_ld_data  = 32'hA5A5_0001;
    #1;
    chk1("b2b_dma_gnt", bus.o_dma_gnt, 1'b1);
    tick();
    bus.i_ld_data = 32'hA5A5_0002;
    #1;
    chk1 ("b2b_rvalid1", bus.o_dma_rvalid, 1'b1);
    chk32("b2b_ld1",     bus.o_dma_ld_data, 32'hA5A5_0001);
    tick();
    bus.i_dma_req = 1'b0;
    #1;
    chk1 ("b2b_rvalid2", bus.o_dma_rvalid, 1'b1);
    chk32("b2b_ld2",     bus.o_dma_ld_data, 32'hA5A5_0002);
    tick();
    #1;
    chk1("b2b_rvalid3", bus.o_dma_rvalid, 1'b0);
    tick();

    // Reset asserted during beat 3 of a locked DMA read burst
    bus.i_dma_req  = 1'b1;
    bus.i_dma_lock = 1'b1;
    bus.i_ld_data  = 32'h5555_AAAA;
    #1;
    chk1("ml_beat1", bus.o_dma_gnt, 1'b1);
    tick();
    #1;
    chk1("ml_beat2", bus.o_dma_gnt, 1'b1);
    tick();
    bus.i_cpu_req  = 1'b1;
    bus.i_cpu_addr = 32'h0000_0500;
    bus.i_cpu_wren = 1'b0;
    #1;
    chk1("ml_beat3",     bus.o_dma_gnt, 1'b1);
    chk1("ml_cpu_stall", bus.o_cpu_stall, 1'b1);
    i_reset = 1'b0;
    #1;
    chk1 ("ml_rst_dma_gnt", bus.o_dma_gnt, 1'b0);
    chk1 ("ml_rst_cpu_gnt", bus.o_cpu_gnt, 1'b0);
    chk1 ("ml_rst_rvalid",  bus.o_dma_rvalid, 1'b0);
    chk32("ml_rst_dma_ld",  bus.o_dma_ld_data, 32'h0);
    chk32("ml_rst_addr",    bus.o_lsu_addr, 32'h0);
    tick();
    i_reset = 1'b1;
    #1;
    chk1 ("ml_rel_cpu_gnt", bus.o_cpu_gnt, 1'b1);
    chk1 ("ml_rel_dma_gnt", bus.o_dma_gnt, 1'b0);
    chk32("ml_rel_addr",    bus.o_lsu_addr, 32'h0000_0500);
    tick();
    #1;
    chk1 ("ml_cpu_rvalid", bus.o_cpu_rvalid, 1'b1);
    chk32("ml_cpu_ld",     bus.o_cpu_ld_data, 32'h5555_AAAA);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_port_arbiter.md
Name: lsu_port_arbiter

Overview:
- Shares the single load/store unit port between two requesters: the pipeline MEM stage (CPU) and a DMA/debug loader (DMA).
- Port 0 is the CPU and port 1 is the DMA.
- Sits between the MEM stage / loader and the LSU, and drives all LSU request inputs.
- Provides fixed CPU priority, DMA anti-starvation, bounded DMA burst locking, and registered load-data return.

Parameters:
- MAX_WAIT, 4: number of consecutive denied DMA request cycles after which the DMA wins over the CPU.
- LOCK_MAX, 8: maximum consecutive locked DMA beats before the lock is forcibly broken for one cycle if the CPU is requesting.

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous active-low reset
- i_cpu_req  in  1  CPU access request (one beat)
- i_cpu_addr  in  32  CPU address
- i_cpu_st_data  in  32  CPU store data
- i_cpu_wren  in  1  CPU write enable
- i_cpu_bmask  in  3  CPU store byte mask code
- i_cpu_sl_sel  in  3  CPU load type select
- o_cpu_gnt  out  1  CPU beat accepted this cycle
- o_cpu_stall  out  1  i_cpu_req & ~o_cpu_gnt
- o_cpu_ld_data  out  32  registered load data
- o_cpu_rvalid  out  1  load data valid (pulse)
- i_dma_req, i_dma_addr, i_dma_st_data, i_dma_wren, i_dma_bmask, i_dma_sl_sel  in  1/32/32/1/3/3  DMA request, same meanings as the CPU inputs
- i_dma_lock  in  1  keep grant for the next beat
- o_dma_gnt, o_dma_ld_data, o_dma_rvalid  out  1/32/1  as CPU
- o_lsu_addr, o_st_data, o_lsu_wren, o_bmask, o_sl_sel  out  32/32/1/3/3  to the LSU
- i_ld_data  in  32  LSU load data, combinational, valid in the same cycle

Behaviour:
- Reset (i_reset=0, asynchronous, any time including mid-burst):
  - State returns to IDLE; wait_cnt=0, lock_cnt=0.
  - o_*_ld_data=0, o_*_rvalid=0.
  - The lock is dropped.
- State register: IDLE, CPU_OWN, DMA_OWN, DMA_LOCK. It records the previous cycle's owner and lock status.
- Grant is combinational from the state, counters and current requests. Priority, highest first:
  1. DMA_LOCK & i_dma_req & ~(lock_cnt==LOCK_MAX & i_cpu_req) -> DMA.
  2. i_dma_req & wait_cnt==MAX_WAIT -> DMA.
  3. i_cpu_req -> CPU.
  4. i_dma_req -> DMA.
  5. Otherwise no grant.
- At most one grant per cycle; o_cpu_gnt and o_dma_gnt are never both 1.
- LSU mux:
  - The granted requester's fields pass straight through in the same cycle.
  - With no grant, o_lsu_addr=0, o_st_data=0, o_lsu_wren=0, o_bmask=0, o_sl_sel=0.
  - o_lsu_wren is never asserted without a grant.
- Next state:
  - DMA granted with i_dma_lock=1 -> DMA_LOCK.
  - DMA granted with i_dma_lock=0 -> DMA_OWN.
  - CPU granted -> CPU_OWN.
  - No grant -> IDLE.
  - DMA_LOCK with i_dma_req=0 -> IDLE; the lock is released.
- wait_cnt:
  - +1 each cycle with i_dma_req & ~o_dma_gnt, saturating at MAX_WAIT.
  - Cleared on o_dma_gnt or when i_dma_req=0.
- lock_cnt:
  - +1 on each DMA grant while in DMA_LOCK, saturating at LOCK_MAX.
  - Cleared on leaving DMA_LOCK or on a forced break.
  - Forced break: the CPU gets that beat; the state becomes CPU_OWN; the DMA request remains pending and wait_cnt counts.
- Load return:
  - A granted read (wren=0) registers i_ld_data into that requester's o_*_ld_data at the clock edge.
  - That requester's o_*_rvalid is 1 for exactly the next cycle.
  - Latency is 1 cycle.
  - Writes produce no rvalid. o_*_ld_data holds its value when there is no read.
- Simultaneous events:
  - CPU and DMA both requesting, with no lock and no starvation: CPU wins.
  - Back-to-back reads by one requester give rvalid on consecutive cycles.

Test Plan:
- Reset with both requests held, then release -> cycle 0 outputs all 0; first cycle after release: o_cpu_gnt=1, o_cpu_stall=0, o_dma_gnt=0.
- CPU read addr 0x0000_0010 while i_ld_data=0xDEADBEEF -> o_lsu_addr=0x10 and o_lsu_wren=0 in the same cycle; next cycle o_cpu_ld_data=0xDEADBEEF and o_cpu_rvalid=1 for exactly one cycle.
- CPU and DMA requesting continuously, no lock, MAX_WAIT=4 -> CPU granted 4 cycles, DMA granted on the 5th, pattern repeats; o_cpu_stall=1 only on DMA cycles.
- DMA locked burst of 12 beats, CPU requesting throughout, LOCK_MAX=8 -> 8 DMA beats, 1 CPU beat, then grants follow the normal priority order with the DMA request still pending.
- DMA store 0x1000_0000 data 0x1FFFF, CPU idle -> o_lsu_wren=1 with o_st_data=0x1FFFF for one cycle; o_dma_rvalid stays 0.
- Assert reset mid-lock (beat 3) -> state IDLE immediately; after release the CPU request wins before the DMA.
